// File: rtl/npu_pkg.sv
// Shared widths, response codes, FSM states and bus payload types for the NPU AXI-Lite bridge.
package npu_pkg;

    localparam int unsigned AXI_A_W         = 32;
    localparam int unsigned AXI_D_W         = 32;
    localparam int unsigned AXI_S_W         = AXI_D_W / 8;
    localparam int unsigned DEF_TIMEOUT_CYC = 256;
    localparam int unsigned TO_CNT_W        = 16;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RSP,
        RD_REQ,
        RD_RSP
    } state_t;

    // Latched write request presented on the address/data bus.
    typedef struct packed {
        logic [AXI_A_W-1:0] addr;
        logic [AXI_D_W-1:0] data;
        logic [AXI_S_W-1:0] strb;
    } wr_req_t;

endpackage

// File: rtl/npu_ad_if.sv
// Simple address/data bus between the bridge (master) and a register-style slave.
interface npu_ad_if;
    import npu_pkg::*;

    logic               w_valid;
    logic               w_ready;
    logic [AXI_A_W-1:0] w_addr;
    logic [AXI_D_W-1:0] w_data;
    logic [AXI_S_W-1:0] w_strb;
    logic               r_valid;
    logic               r_ready;
    logic               rd_ready;
    logic [AXI_A_W-1:0] r_addr;
    logic [AXI_D_W-1:0] r_data;

    modport master (
        output w_valid, w_addr, w_data, w_strb, r_valid, r_addr, rd_ready,
        input  w_ready, r_ready, r_data
    );

    modport slave (
        input  w_valid, w_addr, w_data, w_strb, r_valid, r_addr, rd_ready,
        output w_ready, r_ready, r_data
    );

endinterface

// File: rtl/npu_axil2ad_bridge.sv
// AXI4-Lite slave to address/data bus master bridge: one transaction in flight,
// round-robin write/read arbitration and a bus-ready timeout answering SLVERR.
module npu_axil2ad_bridge
    import npu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
    parameter bit          RD_PRIO_INIT = 1'b0
) (
    input  logic               clk_i,
    input  logic               arstn_i,
    input  logic               s_awvalid,
    output logic               s_awready,
    input  logic [AXI_A_W-1:0] s_awaddr,
    input  logic               s_wvalid,
    output logic               s_wready,
    input  logic [AXI_D_W-1:0] s_wdata,
    input  logic [AXI_S_W-1:0] s_wstrb,
    output logic               s_bvalid,
    input  logic               s_bready,
    output logic [1:0]         s_bresp,
    input  logic               s_arvalid,
    output logic               s_arready,
    input  logic [AXI_A_W-1:0] s_araddr,
    output logic               s_rvalid,
    input  logic               s_rready,
    output logic [AXI_D_W-1:0] s_rdata,
    output logic [1:0]         s_rresp,
    npu_ad_if.master           m_bus,
    output logic               busy_o
);

    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYC - 1);

    state_t              state;
    logic [TO_CNT_W-1:0] to_cnt;
    logic                rd_prio;
    wr_req_t             wr_q;
    logic                w_valid_q;
    logic                r_valid_q;
    logic [AXI_A_W-1:0]  r_addr_q;

    logic wr_pend;
    logic rd_pend;
    logic pick_wr;
    logic to_hit;

    // Arbitration: a write needs both AW and W; ties go to the prioritised side.
    always_comb begin
        wr_pend = s_awvalid && s_wvalid;
        rd_pend = s_arvalid;
        pick_wr = wr_pend && (!rd_pend || !rd_prio);
        to_hit  = (to_cnt == TO_LAST);
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state     <= IDLE;
            to_cnt    <= '0;
            rd_prio   <= RD_PRIO_INIT;
            wr_q      <= '0;
            w_valid_q <= 1'b0;
            r_valid_q <= 1'b0;
            r_addr_q  <= '0;
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
            s_arready <= 1'b0;
            s_bvalid  <= 1'b0;
            s_bresp   <= '0;
            s_rvalid  <= 1'b0;
            s_rdata   <= '0;
            s_rresp   <= '0;
            busy_o    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    // Readies are raised for exactly one cycle; the handshake completes on the next edge.
                    if (s_awready || s_arready) begin
                        s_awready <= 1'b0;
                        s_wready  <= 1'b0;
                        s_arready <= 1'b0;
                        if (s_awready && wr_pend) begin
                            wr_q      <= '{addr: s_awaddr, data: s_wdata, strb: s_wstrb};
                            w_valid_q <= 1'b1;
                            to_cnt    <= '0;
                            rd_prio   <= ~rd_prio;
                            busy_o    <= 1'b1;
                            state     <= WR_REQ;
                        end else if (s_arready && rd_pend) begin
                            r_addr_q  <= s_araddr;
                            r_valid_q <= 1'b1;
                            to_cnt    <= '0;
                            rd_prio   <= ~rd_prio;
                            busy_o    <= 1'b1;
                            state     <= RD_REQ;
                        end
                    end else if (pick_wr) begin
                        s_awready <= 1'b1;
                        s_wready  <= 1'b1;
                    end else if (rd_pend) begin
                        s_arready <= 1'b1;
                    end
                end

                WR_REQ: begin
                    if (w_valid_q && m_bus.w_ready) begin
                        w_valid_q <= 1'b0;
                        s_bvalid  <= 1'b1;
                        s_bresp   <= RESP_OKAY;
                        state     <= WR_RSP;
                    end else if (to_hit) begin
                        w_valid_q <= 1'b0;
                        s_bvalid  <= 1'b1;
                        s_bresp   <= RESP_SLVERR;
                        state     <= WR_RSP;
                    end else begin
                        to_cnt <= to_cnt + TO_CNT_W'(1);
                    end
                end

                WR_RSP: begin
                    if (s_bready) begin
                        s_bvalid <= 1'b0;
                        busy_o   <= 1'b0;
                        state    <= IDLE;
                    end
                end

                RD_REQ: begin
                    if (r_valid_q && m_bus.r_ready) begin
                        r_valid_q <= 1'b0;
                        s_rvalid  <= 1'b1;
                        s_rdata   <= m_bus.r_data;
                        s_rresp   <= RESP_OKAY;
                        state     <= RD_RSP;
                    end else if (to_hit) begin
                        r_valid_q <= 1'b0;
                        s_rvalid  <= 1'b1;
                        s_rdata   <= '0;
                        s_rresp   <= RESP_SLVERR;
                        state     <= RD_RSP;
                    end else begin
                        to_cnt <= to_cnt + TO_CNT_W'(1);
                    end
                end

                RD_RSP: begin
                    if (s_rready) begin
                        s_rvalid <= 1'b0;
                        busy_o   <= 1'b0;
                        state    <= IDLE;
                    end
                end

                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    // rd_ready shares the r_valid register so it can only be high in RD_REQ.
    assign m_bus.w_valid  = w_valid_q;
    assign m_bus.w_addr   = wr_q.addr;
    assign m_bus.w_data   = wr_q.data;
    assign m_bus.w_strb   = wr_q.strb;
    assign m_bus.r_valid  = r_valid_q;
    assign m_bus.r_addr   = r_addr_q;
    assign m_bus.rd_ready = r_valid_q;

endmodule
